rr_sel_enc8: RTL



---
 rtl/rr_sel_enc8.sv | 118 +++++++++++
 1 files changed

// File: rtl/rr_sel_enc8.sv
// 8-requester round-robin arbiter that drives the registered grant index into dec3to8.
// Optional forced release after MAX_HOLD unacked cycles: define RR_HOLD_TIMEOUT_EN.
module rr_sel_enc8 #(
    parameter int unsigned N        = 8,
    parameter int unsigned IDX_W    = 3,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             ack,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic [CNT_W-1:0] gnt_count,
    output logic             timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] win;
    logic             found;
    logic             natural_rel;
    logic             forced;
    logic             rel;

`ifdef RR_HOLD_TIMEOUT_EN
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0] hold_cnt;

    // hold_cnt counts the GRANT cycles already spent, so the grant stays visible
    // for exactly MAX_HOLD cycles before the forced release edge.
    assign forced = (state == GRANT) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
`else
    assign forced  = 1'b0;
    assign timeout = 1'b0;
`endif

    assign natural_rel = ack || !req[gnt_idx];
    assign rel         = (state == GRANT) && (natural_rel || forced);

    // On release the search starts just past the current holder, which equals the new ptr.
    always_comb begin
        base  = (state == GRANT) ? gnt_idx + IDX_W'(1) : ptr;
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[base + IDX_W'(i)]) begin
                win   = base + IDX_W'(i);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            gnt_count <= '0;
`ifdef RR_HOLD_TIMEOUT_EN
            hold_cnt  <= '0;
            timeout   <= 1'b0;
`endif
        end else begin
`ifdef RR_HOLD_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= GRANT;
                        gnt_idx   <= win;
                        gnt_valid <= 1'b1;
                        gnt_count <= gnt_count + CNT_W'(1);
`ifdef RR_HOLD_TIMEOUT_EN
                        hold_cnt  <= '0;
`endif
                    end else begin
                        gnt_idx   <= '0;
                        gnt_valid <= 1'b0;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        ptr <= gnt_idx + IDX_W'(1);
`ifdef RR_HOLD_TIMEOUT_EN
                        timeout  <= forced && !natural_rel;
                        hold_cnt <= '0;
`endif
                        if (found) begin
                            gnt_idx   <= win;
                            gnt_count <= gnt_count + CNT_W'(1);
                        end else begin
                            state     <= IDLE;
                            gnt_idx   <= '0;
                            gnt_valid <= 1'b0;
                        end
                    end else begin
`ifdef RR_HOLD_TIMEOUT_EN
                        hold_cnt <= hold_cnt + HOLD_W'(1);
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt_idx   <= '0;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
